// File: rtl/wb_port_scheduler.sv
// Write-back port scheduler: shares one register-file write port between ALU and a
// fixed-latency multiplier, with RAW/WAW/structural issue stalls. Optional macro: WB_COLLISION_CHK_EN.
module wb_port_scheduler #(
    parameter int REG_ADDR = 5,
    parameter int DATA_W   = 32,
    parameter int ALU_LAT  = 2,
    parameter int MUL_LAT  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic                issue_mul,
    input  logic                issue_we,
    input  logic [REG_ADDR-1:0] issue_ra,
    input  logic [REG_ADDR-1:0] issue_rb,
    input  logic [REG_ADDR-1:0] issue_wb,
    output logic                issue_stall,
    input  logic [DATA_W-1:0]   mul_data,
    input  logic                alu_we,
    input  logic [REG_ADDR-1:0] alu_waddr,
    input  logic [DATA_W-1:0]   alu_wdata,
    output logic                rf_we,
    output logic [REG_ADDR-1:0] rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                mul_busy,
    output logic                wb_collision
);
    localparam int NREG = 2**REG_ADDR;
    localparam int CW   = $clog2(MUL_LAT);
    localparam logic [CW-1:0] ALU_CNT  = CW'(ALU_LAT);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);

    logic                busy;
    logic                mul_we;
    logic [CW-1:0]       cnt;
    logic [REG_ADDR-1:0] mul_dest;
    logic [NREG-1:0]     pending;
    logic [NREG-1:0]     pending_nxt;
    logic                wr_cycle;
    logic                accept;
    logic                st_struct, st_port, st_raw_a, st_raw_b, st_waw;

    assign wr_cycle = busy && (cnt == '0);
    assign mul_busy = busy;

    // A pending register being written this very cycle is bypassed downstream, so it does not stall.
    always_comb begin
        st_struct   = issue_mul && busy && (cnt != '0);
        st_port     = !issue_mul && issue_we && busy && (cnt == ALU_CNT);
        st_raw_a    = (issue_ra != '0) && pending[issue_ra] && !(wr_cycle && (mul_dest == issue_ra));
        st_raw_b    = (issue_rb != '0) && pending[issue_rb] && !(wr_cycle && (mul_dest == issue_rb));
        st_waw      = issue_we && (issue_wb != '0) && pending[issue_wb]
                      && !(wr_cycle && (mul_dest == issue_wb));
        issue_stall = issue_valid && (st_struct || st_port || st_raw_a || st_raw_b || st_waw);
    end

    assign accept = issue_valid && !issue_stall;

    always_comb begin
        rf_we    = alu_we;
        rf_waddr = alu_waddr;
        rf_wdata = alu_wdata;
        if (wr_cycle) begin
            rf_we    = mul_we;
            rf_waddr = mul_dest;
            rf_wdata = mul_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            mul_we   <= 1'b0;
            cnt      <= '0;
            mul_dest <= '0;
        end else if (accept && issue_mul) begin
            busy     <= 1'b1;
            mul_we   <= issue_we;
            cnt      <= MUL_LOAD;
            mul_dest <= issue_wb;
        end else if (busy) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else           busy <= 1'b0;
        end
    end

    // Set after clear so a same-index reissue in the write cycle keeps the bit.
    always_comb begin
        pending_nxt = pending;
        if (wr_cycle) pending_nxt[mul_dest] = 1'b0;
        if (accept && issue_mul && issue_we && (issue_wb != '0)) pending_nxt[issue_wb] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

`ifdef WB_COLLISION_CHK_EN
    logic collision;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            collision <= 1'b0;
        else if (wr_cycle && mul_we && alu_we) collision <= 1'b1;
    end
    assign wb_collision = collision;
`else
    assign wb_collision = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler: stimulus pushes expected per-cycle status and
// expected register-file writes; a negedge monitor pops and compares them.
module tb_wb_port_scheduler;
    localparam int RA = 5;
    localparam int DW = 32;
`ifdef WB_COLLISION_CHK_EN
    localparam int EXP_COL = 1;
`else
    localparam int EXP_COL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid, issue_mul, issue_we;
    logic [RA-1:0] issue_ra, issue_rb, issue_wb;
    logic          issue_stall;
    logic [DW-1:0] mul_data;
    logic          alu_we;
    logic [RA-1:0] alu_waddr;
    logic [DW-1:0] alu_wdata;
    logic          rf_we;
    logic [RA-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          mul_busy, wb_collision;

    wb_port_scheduler #(.REG_ADDR(RA), .DATA_W(DW), .ALU_LAT(2), .MUL_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_mul(issue_mul), .issue_we(issue_we),
        .issue_ra(issue_ra), .issue_rb(issue_rb), .issue_wb(issue_wb),
        .issue_stall(issue_stall), .mul_data(mul_data),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mul_busy(mul_busy), .wb_collision(wb_collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    es;  // expected stall, -1 = don't care
        int    eb;  // expected mul_busy
        int    ec;  // expected wb_collision
    } cexp_t;

    typedef struct {
        int            cyc;
        logic [RA-1:0] addr;
        logic [DW-1:0] data;
    } wexp_t;

    cexp_t cq[$];
    wexp_t wq[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    bit    mon_en = 0;
    bit    mul_fix = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input int c);
        return 32'hA000_0000 | DW'(c & 16'hFFFF);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (cq.size() > 0) begin
                cexp_t e;
                e = cq.pop_front();
                if (e.es >= 0) begin
                    checks++;
                    if (issue_stall !== e.es[0]) begin
                        failures++;
                        $display("FAIL %s stall cyc=%0d got=%b want=%0d", e.nm, cyc, issue_stall, e.es);
                    end
                end
                if (e.eb >= 0) begin
                    checks++;
                    if (mul_busy !== e.eb[0]) begin
                        failures++;
                        $display("FAIL %s mul_busy cyc=%0d got=%b want=%0d", e.nm, cyc, mul_busy, e.eb);
                    end
                end
                if (e.ec >= 0) begin
                    checks++;
                    if (wb_collision !== e.ec[0]) begin
                        failures++;
                        $display("FAIL %s wb_collision cyc=%0d got=%b want=%0d", e.nm, cyc, wb_collision, e.ec);
                    end
                end
            end
            if (rf_we === 1'b1) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h want=none", cyc, rf_waddr, rf_wdata);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    if (w.cyc != cyc || rf_waddr !== w.addr || rf_wdata !== w.data) begin
                        failures++;
                        $display("FAIL rf_write got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                                 cyc, rf_waddr, rf_wdata, w.cyc, w.addr, w.data);
                    end
                end
            end
        end
    end

    task automatic iss(input logic v, input logic m, input logic we,
                       input logic [RA-1:0] ra, input logic [RA-1:0] rb, input logic [RA-1:0] wb);
        issue_valid = v; issue_mul = m; issue_we = we;
        issue_ra = ra; issue_rb = rb; issue_wb = wb;
    endtask

    task automatic alu(input logic we, input logic [RA-1:0] a, input logic [DW-1:0] d);
        alu_we = we; alu_waddr = a; alu_wdata = d;
    endtask

    task automatic idle();
        iss(0, 0, 0, 0, 0, 0);
        alu(0, 0, 0);
    endtask

    // Expect a write 'dly' cycles from now, carrying the multiplier pattern of that cycle.
    task automatic push_mul(input logic [RA-1:0] a, input int dly);
        wexp_t w;
        w.cyc = cyc + dly; w.addr = a;
        w.data = mul_fix ? 32'h30 : pat(cyc + dly);
        wq.push_back(w);
    endtask

    task automatic push_alu(input logic [RA-1:0] a, input logic [DW-1:0] d);
        wexp_t w;
        w.cyc = cyc; w.addr = a; w.data = d;
        wq.push_back(w);
    endtask

    task automatic step(input string nm, input int es, input int eb, input int ec);
        cexp_t e;
        mul_data = mul_fix ? 32'h30 : pat(cyc);
        e.nm = nm; e.es = es; e.eb = eb; e.ec = ec;
        cq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        rst_n = 1'b0; #1; rst_n = 1'b1;
    endtask

    initial begin
        idle();
        mul_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1;

        // reset state and ALU pass-through (including r0)
        iss(1, 0, 0, 5, 6, 0); alu(1, 0, 32'h55);
        push_alu(0, 32'h55);
        step("reset", 0, 0, 0);

        // single multiply: write cycle 4 only, busy 1..4
        idle(); mul_fix = 1;
        iss(1, 1, 1, 0, 0, 5); push_mul(5, 4); step("mul_t0", 0, 0, 0);
        idle();
        for (int t = 1; t <= 4; t++) step("mul_busy", -1, 1, -1);
        step("mul_done", -1, 0, -1);
        mul_fix = 0;

        // RAW stall on reader of r5 (ra, then rb), bypass in write cycle
        iss(1, 1, 1, 0, 0, 5); push_mul(5, 4); step("raw_t0", 0, 0, -1);
        iss(1, 0, 0, 5, 0, 0); step("raw_a1", 1, 1, -1);
        iss(1, 0, 0, 0, 5, 0); step("raw_b2", 1, 1, -1);
        iss(1, 0, 0, 5, 0, 0); step("raw_a3", 1, 1, -1);
        step("raw_byp4", 0, 1, -1);
        idle(); step("raw_idle", 0, 0, -1);

        // write-port stall for ALU writer to r7
        iss(1, 1, 1, 0, 0, 5); push_mul(5, 4); step("wp_t0", 0, 0, -1);
        iss(1, 0, 1, 0, 0, 7); step("wp_t1", 0, 1, -1);
        step("wp_t2", 1, 1, -1);
        step("wp_t3", 0, 1, -1);
        idle(); step("wp_t4", 0, 1, -1);
        step("wp_t5", -1, 0, 0);

        // back-to-back multiplies: writes at 4 and 8
        iss(1, 1, 1, 0, 0, 5); push_mul(5, 4); step("mm_t0", 0, 0, -1);
        iss(1, 1, 1, 0, 0, 6);
        for (int t = 1; t <= 3; t++) step("mm_struct", 1, 1, -1);
        push_mul(6, 4); step("mm_t4", 0, 1, -1);
        idle();
        for (int t = 5; t <= 8; t++) step("mm_busy2", -1, 1, -1);
        step("mm_t9", -1, 0, -1);

        // WAW on r5 until the write cycle
        iss(1, 1, 1, 0, 0, 5); push_mul(5, 4); step("waw_t0", 0, 0, -1);
        iss(1, 0, 1, 0, 0, 5);
        for (int t = 1; t <= 3; t++) step("waw_stall", 1, 1, -1);
        step("waw_t4", 0, 1, -1);
        idle(); step("waw_idle", 0, 0, -1);

        // non-writing multiply holds the unit but produces no write; r0 never pending
        iss(1, 1, 0, 0, 0, 4); step("nw_t0", 0, 0, -1);
        iss(1, 0, 0, 4, 0, 0); step("nw_rd4", 0, 1, -1);
        idle();
        for (int t = 2; t <= 4; t++) step("nw_busy", -1, 1, -1);
        iss(1, 1, 1, 0, 0, 0); push_mul(0, 4); step("r0_t0", 0, 0, -1);
        iss(1, 0, 1, 0, 0, 0); step("r0_rd", 0, 1, -1);
        idle();
        for (int t = 2; t <= 4; t++) step("r0_busy", -1, 1, -1);
        step("r0_done", 0, 0, -1);

        // forced ALU write during multiply write cycle
        iss(1, 1, 1, 0, 0, 9); push_mul(9, 4); step("col_t0", 0, 0, 0);
        idle();
        for (int t = 1; t <= 3; t++) step("col_busy", -1, 1, 0);
        alu(1, 3, 32'hDEAD); step("col_t4", -1, 1, 0);
        alu(0, 0, 0); step("col_t5", -1, 0, EXP_COL);
        pulse_rst(); step("col_rst", -1, 0, 0);

        // reset mid-multiply discards it; reader of r5 accepted at once
        iss(1, 1, 1, 0, 0, 5); step("rm_t0", 0, 0, -1);
        idle(); step("rm_t1", -1, 1, -1);
        pulse_rst(); iss(1, 0, 0, 5, 5, 0); step("rm_t2", 0, 0, 0);
        idle();
        for (int t = 3; t <= 7; t++) step("rm_quiet", 0, 0, 0);

        checks++;
        if (wq.size() != 0) begin
            failures++;
            $display("FAIL missing_writes left=%0d want=0", wq.size());
        end
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_port_scheduler.md
WB_PORT_SCHEDULER -- requirements
Module: wb_port_scheduler

Interface
REQ-001 SHALL have parameter REG_ADDR, default 5, register-file address width (2**REG_ADDR registers).
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter ALU_LAT, default 2, cycles from ALU-class issue to its register-file write cycle.
REQ-004 SHALL have parameter MUL_LAT, default 4, cycles from multiply issue to its register-file write cycle; legal only if MUL_LAT > ALU_LAT >= 1.
REQ-005 SHALL have these ports, one clock; reset is asynchronous and active-low:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  instruction presented for issue
issue_mul  in  1  instruction targets the multiplier
issue_we  in  1  instruction writes a register
issue_ra  in  REG_ADDR  source A address
issue_rb  in  REG_ADDR  source B address
issue_wb  in  REG_ADDR  destination address
issue_stall  out  1  issue refused this cycle
mul_data  in  DATA_W  multiplier result, valid during the multiply write cycle
alu_we  in  1  ALU write-back valid
alu_waddr  in  REG_ADDR  ALU write-back address
alu_wdata  in  DATA_W  ALU write-back data
rf_we  out  1  register-file write enable
rf_waddr  out  REG_ADDR  register-file write address
rf_wdata  out  DATA_W  register-file write data
mul_busy  out  1  multiply outstanding
wb_collision  out  1  sticky port-collision error

Function
REQ-006 SHALL accept an instruction in a cycle iff issue_valid=1 and issue_stall=0; issue_stall SHALL be combinational from current state and issue inputs, and 0 when issue_valid=0.
REQ-007 SHALL hold state: busy bit, countdown cnt (width ceil(log2(MUL_LAT))), mul_dest (REG_ADDR), pending bit-vector (2**REG_ADDR).
REQ-008 On accepted multiply: busy<=1, cnt<=MUL_LAT-1, mul_dest<=issue_wb; while busy and cnt!=0, cnt decrements by 1 each cycle.
REQ-009 Multiply write cycle = busy=1 and cnt=0; in it rf_we=1, rf_waddr=mul_dest, rf_wdata=mul_data, pending[mul_dest] cleared, busy<=0 unless a new multiply is accepted that cycle.
REQ-010 Outside the multiply write cycle: rf_we=alu_we, rf_waddr=alu_waddr, rf_wdata=alu_wdata.
REQ-011 Accepted multiply with issue_we=1 and issue_wb!=0 SHALL set pending[issue_wb]; when clear and set hit the same index in one cycle, set wins.
REQ-012 Structural stall: issue_stall=1 if issue_mul=1 and busy=1 and cnt!=0.
REQ-013 Write-port stall: issue_stall=1 if issue_mul=0, issue_we=1, busy=1 and cnt=ALU_LAT.
REQ-014 RAW stall: issue_stall=1 if a nonzero issue_ra or issue_rb has its pending bit set and the current cycle is not the multiply write cycle for that address (the downstream write-back bypass forwards it).
REQ-015 WAW stall: issue_stall=1 if issue_we=1, issue_wb!=0, pending[issue_wb]=1 and not the multiply write cycle for issue_wb.
REQ-016 Register 0 SHALL never be pending, never cause a stall, but is still written through rf_* when addressed.
REQ-017 mul_busy SHALL equal busy.
REQ-018 A multiply with issue_we=0 SHALL occupy the multiplier and its write cycle with rf_we=0 for that cycle.

Reset
REQ-019 rst_n=0 SHALL asynchronously clear busy, cnt, mul_dest, pending and wb_collision; while busy=0, rf_* follow alu_* per REQ-010.
REQ-020 Reset mid-multiply SHALL discard the multiply: no rf_we for it after release, no residual stall.

Configuration
REQ-021 With WB_COLLISION_CHK_EN defined: wb_collision sets (sticky until reset) in any multiply write cycle with alu_we=1 and the multiply writing (issue_we was 1).
REQ-022 Without WB_COLLISION_CHK_EN: wb_collision tied 0, no checker logic.

Verification
REQ-023 Multiply to r5 issued cycle 0, mul_data=0x0000_0030 -> rf_we=1, rf_waddr=5, rf_wdata=0x30 in cycle 4 only; mul_busy=1 cycles 1-4.
REQ-024 Multiply to r5 cycle 0, ALU reader of r5 cycles 1-3 -> issue_stall=1 cycles 1-3, accepted cycle 4.
REQ-025 Multiply cycle 0, ALU write instruction to r7 held valid from cycle 1 -> stalled cycle 2 only (cnt=2), accepted cycle 3; no collision.
REQ-026 Second multiply presented cycles 1-4 -> stalled 1-3, accepted 4; write cycles 4 and 8.
REQ-027 Forced alu_we=1 in cycle 4 of a multiply -> rf_wdata=mul_data; wb_collision=1 with macro, 0 without; reset clears it.
REQ-028 rst_n pulsed low in cycle 2 of a multiply -> no rf_we for it, mul_busy=0, pending reader of its destination accepted immediately.
